// File: rtl/fft_input_loader.sv
// -----------------------------------------------------------------------------
// fft_input_loader
//
// Front end of the 32-point FFT datapath. It collects a serial stream of
// complex samples into a ping-pong frame store. Each complete frame is
// presented as packed parallel real/imag buses to the stage-0 butterflies.
// While one frame is held for the downstream stage, the other bank loads.
//
// Handshakes (both sides):
//   A beat transfers on a rising clk edge where valid && ready.
//   A source holds its payload stable until that happens.
//   ready never depends combinationally on valid. Both in_ready and out_valid
//   are decoded from registers only.
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous, active-high reset
//   in_valid/in_ready serial sample handshake
//   in_real/in_imag   serial sample (data_width bits each, two's complement)
//   out_valid/out_ready
//                     frame handshake
//   output_data_real  packed frame, slot k at [(k+1)*data_width-1 : k*data_width]
//   output_data_imag  packed frame, same slot layout
//
// Build option:
//   FFT_INPUT_LOADER_BIT_REVERSE_EN - when defined, sample n is stored in the
//   slot given by bit-reversing n. The frame then leaves in the order a
//   decimation-in-time stage 0 expects. When undefined, natural order is used.
// -----------------------------------------------------------------------------
module fft_input_loader #(
  parameter int data_width = 8,
  parameter int no_in_out  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [data_width-1:0]           in_real,
  input  logic [data_width-1:0]           in_imag,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [no_in_out*data_width-1:0] output_data_real,
  output logic [no_in_out*data_width-1:0] output_data_imag
);

  localparam int cw = (no_in_out > 1) ? $clog2(no_in_out) : 1;
  localparam int fw = no_in_out * data_width;
  localparam logic [cw-1:0] last_cnt = cw'(no_in_out - 1);

  // Each bank holds one frame, already packed in output slot order.
  logic [fw-1:0] bank_real [2];
  logic [fw-1:0] bank_imag [2];

  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic [cw-1:0] wr_cnt;
  logic [cw-1:0] wr_slot;
  logic          accept_in;
  logic          accept_out;

  // Map the arrival index to a storage slot.
  function automatic logic [cw-1:0] idx(input logic [cw-1:0] n);
`ifdef FFT_INPUT_LOADER_BIT_REVERSE_EN
    logic [cw-1:0] r;
    r = '0;
    for (int i = 0; i < cw; i++) begin
      r[cw-1-i] = n[i];
    end
    return r;
`else
    return n;
`endif
  endfunction

  assign in_ready   = ~full[wr_bank];
  assign out_valid  = full[rd_bank];
  assign accept_in  = in_valid & in_ready;
  assign accept_out = out_valid & out_ready;
  assign wr_slot    = idx(wr_cnt);

  // The read bank is shown continuously. After a frame is taken, the buses
  // show the other bank. That bank may be partially loaded, so the buses are
  // only meaningful while out_valid is high.
  assign output_data_real = bank_real[rd_bank];
  assign output_data_imag = bank_imag[rd_bank];

  // A frame can complete in the same cycle that another frame is taken.
  // The write bank is never full when accepting, and the read bank is always
  // full when taken. So the two updates below always touch different full bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        bank_real[b] <= '0;
        bank_imag[b] <= '0;
      end
    end else begin
      if (accept_in) begin
        bank_real[wr_bank][int'(wr_slot)*data_width +: data_width] <= in_real;
        bank_imag[wr_bank][int'(wr_slot)*data_width +: data_width] <= in_imag;
        if (wr_cnt == last_cnt) begin
          wr_cnt        <= '0;
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (accept_out) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

endmodule
